systolic_result_drain: RTL and testbench

Result-readout block at the output end of the systolic array. On each new `compute_done` it snapshots the flat accumulator matrix, then streams it out one row per beat over a valid/ready interface. Each element is arithmetically scaled and saturated or truncated to a narrower width on the way out. The snapshot lets the array start the next tile while the previous result drains.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/result_quantizer.sv | 41 ++++
 rtl/systolic_result_drain.sv | 131 +++++++++++++
 tb/tb_systolic_result_drain.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its result readout.
// Contents: drain_state_t (readout FSM states) and default width constants.
package systolic_pkg;

  // Default widths shared with the array: input operand, accumulator, drained output
  localparam int unsigned IP_WIDTH  = 8;
  localparam int unsigned OP_WIDTH  = 48;
  localparam int unsigned OUT_WIDTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/result_quantizer.sv
// Narrows one signed accumulator element to the output width.
// Applies an arithmetic right shift, then either saturates to the signed output
// range (SAT=1) or keeps the low OUT_WIDTH bits (SAT=0). Purely combinational.
// Ports:
//   elem_i : OP_WIDTH-bit signed accumulator value
//   q_o    : OUT_WIDTH-bit signed narrowed value
module result_quantizer #(
  parameter int unsigned OP_WIDTH  = 48,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned SAT       = 1
) (
  input  logic [OP_WIDTH-1:0]  elem_i,
  output logic [OUT_WIDTH-1:0] q_o
);

  // Signed output range expressed at accumulator width for the clamp compare
  localparam logic signed [OP_WIDTH-1:0] MAX_V =
    {{(OP_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OP_WIDTH-1:0] MIN_V =
    {{(OP_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic signed [OP_WIDTH-1:0] shifted_c;

  // Arithmetic shift rounds toward negative infinity
  assign shifted_c = $signed(elem_i) >>> SHIFT;

  if (SAT != 0) begin : g_sat
    always_comb begin
      q_o = shifted_c[OUT_WIDTH-1:0];
      if (shifted_c > MAX_V) begin
        q_o = MAX_V[OUT_WIDTH-1:0];
      end else if (shifted_c < MIN_V) begin
        q_o = MIN_V[OUT_WIDTH-1:0];
      end
    end
  end else begin : g_trunc
    assign q_o = shifted_c[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Result readout for the systolic array.
// On each rising edge of compute_done (while idle) the accumulator matrix is
// snapshotted and streamed out one row per valid/ready beat, each element
// narrowed by result_quantizer. The snapshot frees the array for the next tile.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   compute_done   : level from the array; rising edge marks a new result
//   output_matrix  : flat matrix, element (r,c) at [(r*COLS+c)*OP_WIDTH +: OP_WIDTH]
//   m_valid/m_ready: row beat handshake
//   m_data         : lane c at [c*OUT_WIDTH +: OUT_WIDTH]; zero when not valid
//   m_row, m_last  : row index of the beat, high on row ROWS-1; zero when not valid
//   busy           : snapshot held and not yet drained
//   overrun        : one-cycle pulse when a result edge arrives mid-drain
//   drain_count    : completed drains, wraps at 2^32
module systolic_result_drain #(
  parameter int unsigned ROWS      = 64,
  parameter int unsigned COLS      = 64,
  parameter int unsigned OP_WIDTH  = systolic_pkg::OP_WIDTH,
  parameter int unsigned OUT_WIDTH = systolic_pkg::OUT_WIDTH,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned SAT       = 1,
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          compute_done,
  input  logic [ROWS*COLS*OP_WIDTH-1:0] output_matrix,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [COLS*OUT_WIDTH-1:0]     m_data,
  output logic [ROW_W-1:0]              m_row,
  output logic                          m_last,
  output logic                          busy,
  output logic                          overrun,
  output logic [31:0]                   drain_count
);

  import systolic_pkg::*;

  localparam int unsigned ROW_BITS = COLS * OP_WIDTH;
  localparam int unsigned MAT_BITS = ROWS * ROW_BITS;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  drain_state_t             state_q, state_d;
  logic                     done_prev_q;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [MAT_BITS-1:0]      snap_q, snap_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     ovr_q, ovr_d;
  logic                     rise_c;
  logic [ROW_BITS-1:0]      row_data_c;
  logic [COLS*OUT_WIDTH-1:0] lanes_c;

  // done_prev resets high so a level already asserted out of reset is ignored
  assign rise_c = compute_done & ~done_prev_q;

  // Next-state: capture only when idle; an edge during a drain is reported and dropped
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_c) begin
          snap_d  = output_matrix;
          row_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        ovr_d = rise_c;
        if (m_ready) begin
          if (row_q == LAST_ROW) begin
            cnt_d   = cnt_q + 32'd1;
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      done_prev_q <= 1'b1;
      row_q       <= '0;
      snap_q      <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= compute_done;
      row_q       <= row_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  // Current row of the snapshot, one quantizer per lane
  assign row_data_c = snap_q[row_q * ROW_BITS +: ROW_BITS];

  for (genvar c = 0; c < int'(COLS); c++) begin : g_lane
    result_quantizer #(
      .OP_WIDTH (OP_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT    (SHIFT),
      .SAT      (SAT)
    ) u_quant (
      .elem_i(row_data_c[c*OP_WIDTH +: OP_WIDTH]),
      .q_o   (lanes_c[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Beat payload is derived from registered snapshot/row and forced to zero when idle
  assign m_valid     = (state_q == STREAM);
  assign busy        = (state_q == STREAM);
  assign m_data      = m_valid ? lanes_c : '0;
  assign m_row       = m_valid ? row_q : '0;
  assign m_last      = m_valid && (row_q == LAST_ROW);
  assign overrun     = ovr_q;
  assign drain_count = cnt_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: three instances (saturate, shift-by-4, truncate)
// share stimulus and are checked each cycle against a behavioural model.
module tb_systolic_result_drain;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int OPW = 48;
  localparam int OW  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cd;
  logic               ready;
  logic [R*C*OPW-1:0] mat_bus;

  logic            v_a, v_b, v_t, l_a, l_b, l_t, b_a, b_b, b_t, o_a, o_b, o_t;
  logic [C*OW-1:0] d_a, d_b, d_t;
  logic [1:0]      r_a, r_b, r_t;
  logic [31:0]     n_a, n_b, n_t;

  systolic_result_drain #(.ROWS(R), .COLS(C), .OP_WIDTH(OPW), .OUT_WIDTH(OW), .SHIFT(0), .SAT(1)) dut_a (
    .clk(clk), .rst(rst), .compute_done(cd), .output_matrix(mat_bus), .m_valid(v_a), .m_ready(ready),
    .m_data(d_a), .m_row(r_a), .m_last(l_a), .busy(b_a), .overrun(o_a), .drain_count(n_a));
  systolic_result_drain #(.ROWS(R), .COLS(C), .OP_WIDTH(OPW), .OUT_WIDTH(OW), .SHIFT(4), .SAT(1)) dut_b (
    .clk(clk), .rst(rst), .compute_done(cd), .output_matrix(mat_bus), .m_valid(v_b), .m_ready(ready),
    .m_data(d_b), .m_row(r_b), .m_last(l_b), .busy(b_b), .overrun(o_b), .drain_count(n_b));
  systolic_result_drain #(.ROWS(R), .COLS(C), .OP_WIDTH(OPW), .OUT_WIDTH(OW), .SHIFT(0), .SAT(0)) dut_t (
    .clk(clk), .rst(rst), .compute_done(cd), .output_matrix(mat_bus), .m_valid(v_t), .m_ready(ready),
    .m_data(d_t), .m_row(r_t), .m_last(l_t), .busy(b_t), .overrun(o_t), .drain_count(n_t));

  always #5 clk = ~clk;

  // Reference model state
  longint      mat  [R][C];
  longint      snap [R][C];
  bit          m_busy = 1'b0;
  int          m_rowi = 0;
  int unsigned m_cnt  = 0;
  bit          m_prev = 1'b1;
  bit          m_ovr  = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int ovr_seen;
  int unsigned cnt_start;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Narrowing rule from plain integer arithmetic
  function automatic longint quant(input longint e, input int sh, input bit sat);
    longint v;
    v = e >>> sh;
    if (sat) begin
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
    end else begin
      v = v & 64'hFFFF;
      if (v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic longint lane(input logic [C*OW-1:0] d, input int c);
    logic [OW-1:0] x;
    x = d[c*OW +: OW];
    return longint'($signed(x));
  endfunction

  task automatic drive_mat();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mat_bus[(r*C+c)*OPW +: OPW] = OPW'(mat[r][c]);
  endtask

  // One clock of the transaction-level behaviour
  task automatic model_step();
    bit rise;
    if (rst) begin
      m_busy = 0; m_rowi = 0; m_cnt = 0; m_prev = 1; m_ovr = 0;
      foreach (snap[r, c]) snap[r][c] = 0;
    end else begin
      rise  = cd && !m_prev;
      m_ovr = rise && m_busy;
      if (m_busy) begin
        if (ready) begin
          if (m_rowi == R - 1) begin
            m_cnt++;
            m_busy = 0;
          end else begin
            m_rowi++;
          end
        end
      end else if (rise) begin
        foreach (snap[r, c]) snap[r][c] = mat[r][c];
        m_rowi = 0;
        m_busy = 1;
      end
      m_prev = cd;
    end
  endtask

  task automatic check_all();
    check("m_valid", longint'(v_a), longint'(m_busy));
    check("busy", longint'(b_a), longint'(m_busy));
    check("m_row", longint'(r_a), m_busy ? longint'(m_rowi) : 0);
    check("m_last", longint'(l_a), longint'(m_busy && m_rowi == R - 1));
    check("overrun", longint'(o_a), longint'(m_ovr));
    check("drain_count", longint'(n_a), longint'(m_cnt));
    check("valid_shift", longint'(v_b), longint'(m_busy));
    check("valid_trunc", longint'(v_t), longint'(m_busy));
    for (int c = 0; c < C; c++) begin
      check($sformatf("lane_sat[%0d]", c), lane(d_a, c), m_busy ? quant(snap[m_rowi][c], 0, 1) : 0);
      check($sformatf("lane_shift[%0d]", c), lane(d_b, c), m_busy ? quant(snap[m_rowi][c], 4, 1) : 0);
      check($sformatf("lane_trunc[%0d]", c), lane(d_t, c), m_busy ? quant(snap[m_rowi][c], 0, 0) : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (o_a) ovr_seen++;
  endtask

  task automatic set_ramp();
    foreach (mat[r, c]) mat[r][c] = 4 * r + c;
    drive_mat();
  endtask

  function automatic longint rand_elem();
    longint x;
    x = longint'({$urandom(), $urandom()});
    case ($urandom_range(0, 3))
      0: x = x >>> 56;
      1: x = x >>> 40;
      2: x = 32767 * 16 + longint'($urandom_range(0, 64)) - 32;
      default: x = x >>> 16;
    endcase
    if ($urandom_range(0, 1) == 1 && x > 0) x = -x;
    return x;
  endfunction

  initial begin
    rst = 1; cd = 0; ready = 0; mat_bus = '0;
    foreach (mat[r, c]) mat[r][c] = 0;
    foreach (snap[r, c]) snap[r][c] = 0;

    // Reset with compute_done low
    @(negedge clk);
    tick(); tick();
    check("rst_valid", longint'(v_a), 0);
    check("rst_cnt", longint'(n_a), 0);
    rst = 0;
    tick();

    // Basic drain with ready held high
    set_ramp();
    ready = 1; cd = 1;
    tick();
    check("basic_row0_lane1", lane(d_a, 1), 1);
    tick(); tick(); tick();
    check("basic_last", longint'(l_a), 1);
    check("basic_lane_r3c2", lane(d_a, 2), 14);
    tick();
    check("basic_cnt", longint'(n_a), 1);
    check("basic_busy", longint'(b_a), 0);

    // Backpressure on row 1 while the input matrix changes
    cd = 0; tick();
    cd = 1; tick();
    tick();
    ready = 0;
    foreach (mat[r, c]) mat[r][c] = 7;
    drive_mat();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_row", longint'(r_a), 1);
      check("bp_lane0", lane(d_a, 0), 4);
    end
    ready = 1;
    tick(); tick(); tick();
    check("bp_cnt", longint'(n_a), 2);

    // Narrowing corner values in row 0
    foreach (mat[r, c]) mat[r][c] = rand_elem();
    mat[0][0] = 40000; mat[0][1] = -40000; mat[0][2] = -17; mat[0][3] = 64'h10005;
    drive_mat();
    ready = 0; cd = 0; tick();
    cd = 1; tick();
    check("sat_pos", lane(d_a, 0), 32767);
    check("sat_neg", lane(d_a, 1), -32768);
    check("shift_neg", lane(d_b, 2), -2);
    check("trunc", lane(d_t, 3), 5);
    ready = 1;
    for (int i = 0; i < 5; i++) tick();

    // Overrun: compute_done falls and rises while row 2 is stalled
    foreach (mat[r, c]) mat[r][c] = rand_elem();
    drive_mat();
    cnt_start = m_cnt;
    cd = 0; tick();
    cd = 1; tick();
    tick(); tick();
    ready = 0;
    ovr_seen = 0;
    cd = 0; tick();
    cd = 1; tick();
    tick();
    ready = 1;
    for (int i = 0; i < 4; i++) tick();
    check("ovr_pulses", longint'(ovr_seen), 1);
    check("ovr_cnt", longint'(n_a), longint'(cnt_start + 1));

    // Edge coinciding with the final handshake is dropped
    cd = 0; tick();
    cd = 1; tick();
    cd = 0;
    tick(); tick(); tick();
    cd = 1; tick();
    check("final_edge_ovr", longint'(o_a), 1);
    tick(); tick();
    check("final_edge_idle", longint'(b_a), 0);

    // Mid-stream reset with compute_done held high
    cd = 0; tick();
    cd = 1; tick();
    tick();
    rst = 1; tick();
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    check("midrst_idle", longint'(b_a), 0);
    check("midrst_cnt", longint'(n_a), 0);
    cd = 0; tick();
    cd = 1; tick();
    check("midrst_recapture", longint'(b_a), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) cd = ~cd;
      if ($urandom_range(0, 3) == 0) begin
        foreach (mat[r, c]) mat[r][c] = rand_elem();
        drive_mat();
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
